// File: rtl/i2c_burst_ctrl.sv
// rtl/i2c_burst_ctrl.sv - burst register-access sequencer for the i2c_master core
//
// Drives the i2c_master 8-bit register bus to run multi-byte register reads and
// writes against a 7-bit slave supplied per request.
//   Clk, Rst_n            : clock, asynchronous active-low reset
//   Dbus_addr/do/wr, di   : i2c_master register bus (di combinational on addr)
//   Req_*                 : request, sampled on Req_start while idle
//   Wr_data/valid/ready   : write-byte stream, one byte per valid&ready
//   Rd_data/valid         : received-byte stream, no back-pressure
//   Busy, Done, Err, Err_code : status (code 1 NACK, 2 arb lost, 3 timeout)
module i2c_burst_ctrl #(
    parameter logic [15:0] PRESCALE  = 16'h003D,
    parameter int          LWIDTH    = 4,
    parameter int          TO_CYCLES = 65535,
    parameter int          TWIDTH    = 16
) (
    input  logic              Clk,
    input  logic              Rst_n,
    output logic [2:0]        Dbus_addr,
    input  logic [7:0]        Dbus_di,
    output logic [7:0]        Dbus_do,
    output logic              Dbus_wr,
    input  logic              Req_start,
    input  logic              Req_rdwr,
    input  logic [6:0]        Req_saddr,
    input  logic [7:0]        Req_raddr,
    input  logic [LWIDTH-1:0] Req_len,
    input  logic [7:0]        Wr_data,
    input  logic              Wr_valid,
    output logic              Wr_ready,
    output logic [7:0]        Rd_data,
    output logic              Rd_valid,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    output logic [1:0]        Err_code
);
    localparam logic [3:0] S_INIT_LO   = 4'd0;
    localparam logic [3:0] S_INIT_HI   = 4'd1;
    localparam logic [3:0] S_INIT_EN   = 4'd2;
    localparam logic [3:0] S_IDLE      = 4'd3;
    localparam logic [3:0] S_TXR       = 4'd4;
    localparam logic [3:0] S_DLOAD     = 4'd5;
    localparam logic [3:0] S_CR        = 4'd6;
    localparam logic [3:0] S_POLL      = 4'd7;
    localparam logic [3:0] S_GET       = 4'd8;
    localparam logic [3:0] S_STOP      = 4'd9;
    localparam logic [3:0] S_STOP_POLL = 4'd10;
    localparam logic [3:0] S_FINISH    = 4'd11;

    // Which byte of the transaction is in flight.
    localparam logic [2:0] P_SLAW  = 3'd0;
    localparam logic [2:0] P_RADDR = 3'd1;
    localparam logic [2:0] P_SLAR  = 3'd2;
    localparam logic [2:0] P_WDATA = 3'd3;
    localparam logic [2:0] P_RDATA = 3'd4;

    localparam logic [TWIDTH-1:0] TO_LAST = TWIDTH'(TO_CYCLES - 1);

    logic [3:0]        state, nstate;
    logic [2:0]        phase_q;
    logic              rdwr_q;
    logic [6:0]        saddr_q;
    logic [7:0]        raddr_q;
    logic [LWIDTH-1:0] remain_q;
    logic [TWIDTH-1:0] tcnt;
    logic              err_q;
    logic [1:0]        code_q, code_n;
    logic [7:0]        rd_data_q;
    logic              rd_valid_q;
    logic [2:0]        addr_c;
    logic [7:0]        do_c, tx_byte, cmd_byte;
    logic              wr_c, last, tip, al, nack, byte_ok;

    assign last = (remain_q == LWIDTH'(1));
    assign tip  = Dbus_di[1];
    assign al   = Dbus_di[5];
    // RxACK only means something for bytes we transmitted.
    assign nack = Dbus_di[7] && (phase_q != P_RDATA);
    assign byte_ok = (state == S_POLL) && !tip && !al && !nack;

    always_comb begin
        tx_byte = 8'h00;
        case (phase_q)
            P_SLAW:  tx_byte = {saddr_q, 1'b0};
            P_RADDR: tx_byte = raddr_q;
            P_SLAR:  tx_byte = {saddr_q, 1'b1};
            default: tx_byte = 8'h00;
        endcase
        cmd_byte = 8'h10;
        case (phase_q)
            P_SLAW, P_SLAR: cmd_byte = 8'h90;
            P_WDATA:        cmd_byte = last ? 8'h50 : 8'h10;
            P_RDATA:        cmd_byte = last ? 8'h68 : 8'h20;
            default:        cmd_byte = 8'h10;
        endcase
    end

    // Bus drive depends only on state, never on Dbus_di, so the core's
    // combinational read path cannot close a loop through this block.
    always_comb begin
        addr_c   = 3'd4;
        do_c     = 8'h00;
        wr_c     = 1'b0;
        Wr_ready = 1'b0;
        case (state)
            S_INIT_LO: begin addr_c = 3'd0; do_c = PRESCALE[7:0];  wr_c = 1'b1; end
            S_INIT_HI: begin addr_c = 3'd1; do_c = PRESCALE[15:8]; wr_c = 1'b1; end
            S_INIT_EN: begin addr_c = 3'd2; do_c = 8'h80;          wr_c = 1'b1; end
            S_TXR:     begin addr_c = 3'd3; do_c = tx_byte;        wr_c = 1'b1; end
            S_DLOAD: begin
                Wr_ready = 1'b1;
                if (Wr_valid) begin
                    addr_c = 3'd3;
                    do_c   = Wr_data;
                    wr_c   = 1'b1;
                end
            end
            S_CR:      begin do_c = cmd_byte; wr_c = 1'b1; end
            S_GET:     addr_c = 3'd3;
            S_STOP:    begin do_c = 8'h40; wr_c = 1'b1; end
            default:   ;
        endcase
    end

    always_comb begin
        nstate = state;
        code_n = code_q;
        case (state)
            S_INIT_LO: nstate = S_INIT_HI;
            S_INIT_HI: nstate = S_INIT_EN;
            S_INIT_EN: nstate = S_IDLE;
            S_IDLE:    if (Req_start) nstate = (Req_len == '0) ? S_FINISH : S_TXR;
            S_TXR:     nstate = S_CR;
            S_DLOAD:   if (Wr_valid) nstate = S_CR;
            S_CR:      nstate = S_POLL;
            S_POLL: begin
                if (!tip) begin
                    // Arbitration loss wins: the core already dropped the bus.
                    if (al) begin
                        code_n = 2'd2;
                        nstate = S_FINISH;
                    end else if (nack) begin
                        code_n = 2'd1;
                        nstate = S_STOP;
                    end else begin
                        case (phase_q)
                            P_SLAW:  nstate = S_TXR;
                            P_RADDR: nstate = rdwr_q ? S_TXR : S_DLOAD;
                            P_SLAR:  nstate = S_CR;
                            P_WDATA: nstate = last ? S_FINISH : S_DLOAD;
                            default: nstate = S_GET;
                        endcase
                    end
                end else if (tcnt == TO_LAST) begin
                    code_n = 2'd3;
                    nstate = S_STOP;
                end
            end
            S_GET:       nstate = last ? S_FINISH : S_CR;
            // After a timeout the core is presumed wedged; do not wait on it.
            S_STOP:      nstate = (code_q == 2'd3) ? S_FINISH : S_STOP_POLL;
            S_STOP_POLL: if (!tip || tcnt == TO_LAST) nstate = S_FINISH;
            S_FINISH:    nstate = S_IDLE;
            default:     nstate = S_INIT_LO;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= S_INIT_LO;
            phase_q    <= P_SLAW;
            rdwr_q     <= 1'b0;
            saddr_q    <= 7'h00;
            raddr_q    <= 8'h00;
            remain_q   <= '0;
            tcnt       <= '0;
            err_q      <= 1'b0;
            code_q     <= 2'd0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
        end else begin
            state      <= nstate;
            rd_valid_q <= 1'b0;
            code_q     <= code_n;
            if (nstate == S_FINISH && state != S_FINISH && code_n != 2'd0)
                err_q <= 1'b1;
            case (state)
                S_IDLE: if (Req_start) begin
                    rdwr_q   <= Req_rdwr;
                    saddr_q  <= Req_saddr;
                    raddr_q  <= Req_raddr;
                    remain_q <= Req_len;
                    phase_q  <= P_SLAW;
                    code_q   <= 2'd0;
                    err_q    <= (Req_len == '0);
                end
                S_CR, S_STOP: tcnt <= '0;
                S_POLL: begin
                    tcnt <= tcnt + TWIDTH'(1);
                    if (byte_ok) begin
                        case (phase_q)
                            P_SLAW:  phase_q <= P_RADDR;
                            P_RADDR: phase_q <= rdwr_q ? P_SLAR : P_WDATA;
                            P_SLAR:  phase_q <= P_RDATA;
                            P_WDATA: if (!last) remain_q <= remain_q - LWIDTH'(1);
                            default: ;
                        endcase
                    end
                end
                S_GET: begin
                    rd_data_q  <= Dbus_di;
                    rd_valid_q <= 1'b1;
                    if (!last) remain_q <= remain_q - LWIDTH'(1);
                end
                S_STOP_POLL: tcnt <= tcnt + TWIDTH'(1);
                default: ;
            endcase
        end
    end

    // State already sits at INIT_LO during reset; keep the bus quiet until release.
    assign Dbus_addr = Rst_n ? addr_c : 3'd4;
    assign Dbus_do   = Rst_n ? do_c : 8'h00;
    assign Dbus_wr   = Rst_n & wr_c;
    assign Rd_data   = rd_data_q;
    assign Rd_valid  = rd_valid_q;
    assign Done      = (state == S_FINISH);
    assign Busy      = (state > S_IDLE) && (state != S_FINISH);
    assign Err       = err_q;
    assign Err_code  = code_q;
endmodule

// File: tb/tb_i2c_burst_ctrl.sv
// tb/tb_i2c_burst_ctrl.sv - scoreboard bench for i2c_burst_ctrl with an i2c_master register model
module tb_i2c_burst_ctrl;
    localparam int TO = 100;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic [2:0] Dbus_addr;
    logic [7:0] Dbus_di, Dbus_do;
    logic       Dbus_wr;
    logic       Req_start = 1'b0, Req_rdwr = 1'b0;
    logic [6:0] Req_saddr = 7'h00;
    logic [7:0] Req_raddr = 8'h00;
    logic [3:0] Req_len = 4'h0;
    logic [7:0] Wr_data = 8'h00;
    logic       Wr_valid = 1'b0, Wr_ready;
    logic [7:0] Rd_data;
    logic       Rd_valid, Busy, Done, Err;
    logic [1:0] Err_code;

    int checks = 0;
    int failures = 0;

    i2c_burst_ctrl #(.PRESCALE(16'h003D), .LWIDTH(4), .TO_CYCLES(TO), .TWIDTH(16)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Dbus_addr(Dbus_addr), .Dbus_di(Dbus_di),
        .Dbus_do(Dbus_do), .Dbus_wr(Dbus_wr), .Req_start(Req_start), .Req_rdwr(Req_rdwr),
        .Req_saddr(Req_saddr), .Req_raddr(Req_raddr), .Req_len(Req_len),
        .Wr_data(Wr_data), .Wr_valid(Wr_valid), .Wr_ready(Wr_ready),
        .Rd_data(Rd_data), .Rd_valid(Rd_valid), .Busy(Busy), .Done(Done),
        .Err(Err), .Err_code(Err_code)
    );

    always #5 Clk = ~Clk;

    // ---------------- i2c_master register model ----------------
    int         nack_at = -1;
    int         al_at = -1;
    bit         tip_forever = 1'b0;
    logic [7:0] rd_src[$];
    logic       m_tip, m_rxack, m_al, m_byte, m_rd;
    logic [7:0] m_rxr;
    int         m_cnt, m_idx, rd_i;

    always_comb begin
        Dbus_di = 8'h00;
        if (Dbus_addr == 3'd4) Dbus_di = {m_rxack, 1'b0, m_al, 3'b000, m_tip, 1'b0};
        else if (Dbus_addr == 3'd3) Dbus_di = m_rxr;
    end

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            m_tip <= 1'b0; m_rxack <= 1'b0; m_al <= 1'b0; m_byte <= 1'b0; m_rd <= 1'b0;
            m_rxr <= 8'h00; m_cnt <= 0; m_idx <= 0; rd_i <= 0;
        end else begin
            if (!Busy) begin m_idx <= 0; rd_i <= 0; end
            if (Dbus_wr && Dbus_addr == 3'd4) begin
                m_al <= 1'b0; m_rxack <= 1'b0;
                if (Dbus_do[7:4] != 4'h0) begin
                    m_tip <= 1'b1; m_cnt <= 3;
                    m_byte <= Dbus_do[5] | Dbus_do[4];
                    m_rd <= Dbus_do[5];
                end
            end else if (m_tip && !tip_forever) begin
                if (m_cnt == 1) begin
                    m_tip <= 1'b0;
                    if (m_byte) begin
                        m_idx <= m_idx + 1;
                        if (m_idx == nack_at) m_rxack <= 1'b1;
                        if (m_idx == al_at) m_al <= 1'b1;
                        if (m_rd) begin
                            m_rxr <= (rd_i < rd_src.size()) ? rd_src[rd_i] : 8'hFF;
                            rd_i <= rd_i + 1;
                        end
                    end
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    logic [10:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    logic [7:0]  wq[$];
    int cyc = 0, cr90_cyc = 0, cr40_cyc = 0, n_stop = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    always begin
        logic [10:0] e;
        logic [7:0]  r;
        @(negedge Clk);
        #2;
        if (Dbus_wr) begin
            checks++;
            if (exp_wr.size() == 0) begin
                failures++;
                $display("FAIL dbus_write: got addr %0d data %02h, required no write", Dbus_addr, Dbus_do);
            end else begin
                e = exp_wr.pop_front();
                if ({Dbus_addr, Dbus_do} !== e) begin
                    failures++;
                    $display("FAIL dbus_write: got addr %0d data %02h, required addr %0d data %02h",
                             Dbus_addr, Dbus_do, e[10:8], e[7:0]);
                end
            end
            if (Dbus_addr == 3'd4 && Dbus_do == 8'h90) cr90_cyc = cyc;
            if (Dbus_addr == 3'd4 && Dbus_do == 8'h40) begin cr40_cyc = cyc; n_stop++; end
        end
        if (Rd_valid) begin
            checks++;
            if (exp_rd.size() == 0) begin
                failures++;
                $display("FAIL rd_data: got unexpected %02h, required no Rd_valid", Rd_data);
            end else begin
                r = exp_rd.pop_front();
                if (Rd_data !== r) begin
                    failures++;
                    $display("FAIL rd_data: got %02h, required %02h", Rd_data, r);
                end
            end
        end
    end

    function automatic logic [10:0] w(input logic [2:0] a, input logic [7:0] d);
        return {a, d};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic start_req(input logic rdwr, input logic [6:0] sa, input logic [7:0] ra, input logic [3:0] len);
        @(negedge Clk);
        Req_rdwr = rdwr; Req_saddr = sa; Req_raddr = ra; Req_len = len; Req_start = 1'b1;
        @(negedge Clk);
        Req_start = 1'b0;
        // Scrambled while busy: must not affect the burst.
        Req_saddr = 7'($urandom); Req_raddr = 8'($urandom); Req_len = 4'($urandom); Req_rdwr = 1'($urandom);
    endtask

    task automatic run_txn(input string name, input int max_cyc, input int stall,
                           output logic done_s, output logic err_s, output logic [1:0] code_s,
                           output int hs, output int stalled, output int stall_wr);
        logic hs_pend;
        int   left;
        hs_pend = 1'b0; left = stall;
        done_s = 1'b0; err_s = 1'b0; code_s = 2'd0; hs = 0; stalled = 0; stall_wr = 0;
        for (int n = 0; n < max_cyc && !done_s; n++) begin
            @(negedge Clk);
            if (hs_pend) begin void'(wq.pop_front()); hs_pend = 1'b0; end
            if (Done) begin done_s = 1'b1; err_s = Err; code_s = Err_code; end
            if (hs >= 1 && left > 0 && Wr_ready) begin
                Wr_valid = 1'b0; left--; stalled++;
            end else begin
                Wr_valid = (wq.size() > 0);
                Wr_data  = (wq.size() > 0) ? wq[0] : 8'h00;
            end
            #1;
            if (Wr_valid && Wr_ready) begin hs_pend = 1'b1; hs++; end
            if (Wr_ready && !Wr_valid && Dbus_wr) stall_wr++;
        end
        Wr_valid = 1'b0;
        checks++;
        if (!done_s) begin
            failures++;
            $display("FAIL %s_done: got no Done within %0d cycles, required Done", name, max_cyc);
        end
        @(negedge Clk);
        #3;
    endtask

    task automatic reset_and_init(input string name);
        Rst_n = 1'b0; Req_start = 1'b0; Wr_valid = 1'b0;
        @(negedge Clk);
        #1;
        checks++;
        if ({Dbus_addr, Dbus_wr, Dbus_do, Wr_ready, Rd_data, Rd_valid, Busy, Done, Err, Err_code} !==
            {3'd4, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0}) begin
            failures++;
            $display("FAIL %s_reset_vals: got addr %0d wr %b do %02h busy %b done %b err %b code %0d, required addr 4 and all else 0",
                     name, Dbus_addr, Dbus_wr, Dbus_do, Busy, Done, Err, Err_code);
        end
        exp_wr.delete(); exp_rd.delete(); wq.delete();
        exp_wr.push_back(w(3'd0, 8'h3D));
        exp_wr.push_back(w(3'd1, 8'h00));
        exp_wr.push_back(w(3'd2, 8'h80));
        @(negedge Clk);
        Rst_n = 1'b1;
        repeat (10) @(negedge Clk);
        #3;
        checks++;
        if (exp_wr.size() != 0) begin
            failures++;
            $display("FAIL %s_init_writes: got %0d init writes missing, required 0", name, exp_wr.size());
        end
        checks++;
        if (Busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle_busy: got %b, required 0", name, Busy);
        end
    endtask

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    // ---------------- scenarios ----------------
    logic       d_s, e_s;
    logic [1:0] c_s;
    int         hs_n, st_n, sw_n;

    task automatic test_reset();
        reset_and_init("reset");
    endtask

    task automatic test_write();
        nack_at = -1; al_at = -1;
        wq = '{8'h27, 8'hA0};
        exp_wr = '{w(3, 8'hEC), w(4, 8'h90), w(3, 8'hF4), w(4, 8'h10),
                   w(3, 8'h27), w(4, 8'h10), w(3, 8'hA0), w(4, 8'h50)};
        start_req(1'b0, 7'h76, 8'hF4, 4'd2);
        run_txn("write", 500, 0, d_s, e_s, c_s, hs_n, st_n, sw_n);
        chk("write_err", int'(e_s), 0);
        chk("write_handshakes", hs_n, 2);
        chk("write_seq_left", exp_wr.size(), 0);
    endtask

    task automatic test_read();
        rd_src = '{8'h80, 8'h00, 8'h00};
        exp_rd = '{8'h80, 8'h00, 8'h00};
        exp_wr = '{w(3, 8'hEC), w(4, 8'h90), w(3, 8'hFA), w(4, 8'h10), w(3, 8'hED),
                   w(4, 8'h90), w(4, 8'h20), w(4, 8'h20), w(4, 8'h68)};
        start_req(1'b1, 7'h76, 8'hFA, 4'd3);
        run_txn("read", 500, 0, d_s, e_s, c_s, hs_n, st_n, sw_n);
        chk("read_err", int'(e_s), 0);
        chk("read_seq_left", exp_wr.size(), 0);
        chk("read_bytes_left", exp_rd.size(), 0);
    endtask

    task automatic test_nack();
        nack_at = 0;
        wq = '{8'h11, 8'h22};
        exp_wr = '{w(3, 8'hEC), w(4, 8'h90), w(4, 8'h40)};
        start_req(1'b0, 7'h76, 8'hF4, 4'd2);
        run_txn("nack", 500, 0, d_s, e_s, c_s, hs_n, st_n, sw_n);
        nack_at = -1;
        wq.delete();
        chk("nack_err", int'(e_s), 1);
        chk("nack_code", int'(c_s), 1);
        chk("nack_handshakes", hs_n, 0);
        chk("nack_seq_left", exp_wr.size(), 0);
    endtask

    task automatic test_timeout();
        tip_forever = 1'b1;
        exp_wr = '{w(3, 8'hEC), w(4, 8'h90), w(4, 8'h40)};
        start_req(1'b0, 7'h76, 8'hF4, 4'd1);
        run_txn("timeout", 400, 0, d_s, e_s, c_s, hs_n, st_n, sw_n);
        tip_forever = 1'b0;
        chk("timeout_code", int'(c_s), 3);
        chk("timeout_err", int'(e_s), 1);
        chk("timeout_poll_span", cr40_cyc - cr90_cyc, TO + 1);
        chk("timeout_seq_left", exp_wr.size(), 0);
        repeat (6) @(negedge Clk);
    endtask

    task automatic test_arb_lost();
        int stops0;
        stops0 = n_stop;
        al_at = 0;
        wq = '{8'h55};
        exp_wr = '{w(3, 8'hEC), w(4, 8'h90)};
        start_req(1'b0, 7'h76, 8'hF4, 4'd1);
        run_txn("arb", 500, 0, d_s, e_s, c_s, hs_n, st_n, sw_n);
        al_at = -1;
        wq.delete();
        chk("arb_code", int'(c_s), 2);
        chk("arb_err", int'(e_s), 1);
        chk("arb_no_stop", n_stop - stops0, 0);
        chk("arb_seq_left", exp_wr.size(), 0);
    endtask

    task automatic test_stall();
        wq = '{8'h11, 8'h22, 8'h33};
        exp_wr = '{w(3, 8'h54), w(4, 8'h90), w(3, 8'h10), w(4, 8'h10), w(3, 8'h11), w(4, 8'h10),
                   w(3, 8'h22), w(4, 8'h10), w(3, 8'h33), w(4, 8'h50)};
        start_req(1'b0, 7'h2A, 8'h10, 4'd3);
        run_txn("stall", 800, 50, d_s, e_s, c_s, hs_n, st_n, sw_n);
        chk("stall_cycles", st_n, 50);
        chk("stall_bus_writes", sw_n, 0);
        chk("stall_handshakes", hs_n, 3);
        chk("stall_err", int'(e_s), 0);
        chk("stall_seq_left", exp_wr.size(), 0);
    endtask

    task automatic test_len_zero();
        start_req(1'b0, 7'h33, 8'h44, 4'd0);
        chk("len0_done", int'(Done), 1);
        chk("len0_err", int'(Err), 1);
        chk("len0_code", int'(Err_code), 0);
        repeat (5) @(negedge Clk);
    endtask

    task automatic test_back_to_back();
        wq = '{8'h5A};
        exp_wr = '{w(3, 8'h20), w(4, 8'h90), w(3, 8'h01), w(4, 8'h10), w(3, 8'h5A), w(4, 8'h50)};
        start_req(1'b0, 7'h10, 8'h01, 4'd1);
        for (int n = 0; n < 300 && !Done; n++) begin
            @(negedge Clk);
            Wr_valid = (wq.size() > 0); Wr_data = (wq.size() > 0) ? wq[0] : 8'h00;
            #1;
            if (Wr_valid && Wr_ready) begin @(posedge Clk); #1; void'(wq.pop_front()); Wr_valid = 1'b0; end
        end
        chk("b2b_first_done", int'(Done), 1);
        start_req(1'b0, 7'h10, 8'h01, 4'd0);
        chk("b2b_second_done", int'(Done), 1);
        chk("b2b_seq_left", exp_wr.size(), 0);
        repeat (3) @(negedge Clk);
    endtask

    task automatic test_reset_mid_read();
        rd_src = '{8'h01, 8'h02, 8'h03};
        exp_rd = '{8'h01, 8'h02, 8'h03};
        exp_wr = '{w(3, 8'hEC), w(4, 8'h90), w(3, 8'hFA), w(4, 8'h10), w(3, 8'hED),
                   w(4, 8'h90), w(4, 8'h20), w(4, 8'h20), w(4, 8'h68)};
        start_req(1'b1, 7'h76, 8'hFA, 4'd3);
        repeat (12) @(negedge Clk);
        #2 Rst_n = 1'b0;
        #1;
        chk("midrst_async_busy", int'(Busy), 0);
        chk("midrst_async_addr", int'(Dbus_addr), 4);
        reset_and_init("midrst");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_nack();
        test_timeout();
        test_arb_lost();
        test_stall();
        test_len_zero();
        test_back_to_back();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/i2c_burst_ctrl.md
Name: i2c_burst_ctrl

Overview:
- Generic, parametrised I2C register-access sequencer that drives the OpenCores i2c_master core through its 8-bit register bus (Dbus_*).
- Successor to the single-device, single-byte sensor controller:
  - slave address supplied per request;
  - multi-byte burst reads and writes with streaming data handshakes;
  - runtime NACK, arbitration-lost and timeout detection, with error reporting.
- Sits between sensor/application FSMs and the i2c_master core.

Parameters:
PRESCALE, 16'h003D, value written to PRERlo/PRERhi at init (SCL = Clk/(5*(PRESCALE+1)))
LWIDTH, 4, width of burst length field (max burst 2^LWIDTH-1 bytes)
TO_CYCLES, 65535, max Clk cycles spent polling TIP for one byte before timeout
TWIDTH, 16, width of timeout counter (must hold TO_CYCLES)

Ports:
Clk  in  1  master clock
Rst_n  in  1  reset
Dbus_addr  out  3  i2c_master register address (0 PRERlo,1 PRERhi,2 CTR,3 TXR/RXR,4 CR/SR)
Dbus_di  in  8  read data from core, combinational on Dbus_addr
Dbus_do  out  8  write data to core
Dbus_wr  out  1  write strobe, one cycle per register write
Req_start  in  1  pulse in IDLE: launch transaction
Req_rdwr  in  1  1=read burst, 0=write burst; sampled with Req_start
Req_saddr  in  7  7-bit slave address; sampled with Req_start
Req_raddr  in  8  slave register start address; sampled with Req_start
Req_len  in  LWIDTH  byte count; sampled with Req_start
Wr_data  in  8  next write byte
Wr_valid  in  1  Wr_data valid
Wr_ready  out  1  block consumes Wr_data this cycle (when Wr_valid=1)
Rd_data  out  8  received byte
Rd_valid  out  1  one-cycle pulse per received byte
Busy  out  1  high from Req_start acceptance until Done
Done  out  1  one-cycle pulse at transaction end (success or error)
Err  out  1  qualifies Done; held until next accepted Req_start
Err_code  out  2  1=NACK, 2=arbitration lost, 3=timeout, 0=none/len-zero

Behaviour:
Interface:
- One clock, Clk.
- Reset is asynchronous, active-low (Rst_n).

Reset values:
- Every output is 0, except Dbus_addr = 4 (SR).
- State = INIT_LO.

Initialisation (one cycle each, Dbus_wr=1):
- INIT_LO: PRERlo <= PRESCALE[7:0].
- INIT_HI: PRERhi <= PRESCALE[15:8].
- INIT_EN: CTR <= 8'h80.
- Then IDLE.
- Req_start during init is ignored.

Default: every cycle not writing drives Dbus_addr=4 (SR), Dbus_wr=0.

Request acceptance (IDLE):
- Req_start=1 latches Req_rdwr, Req_saddr, Req_raddr and Req_len into internal registers and raises Busy.
- Req_len=0: Done=1 and Err=1, Err_code=0 the next cycle; no bus activity.

Byte issue: each byte is issued as TXR write (if transmitting), then CR write, then POLL.
- POLL: read SR until TIP (bit1)=0.
- Timeout counter: cleared on CR write, incremented each POLL cycle.

Write burst:
- SLA+W with CR=8'h90 (STA|WR).
- Raddr with CR=8'h10.
- Req_len data bytes, each CR=8'h10; the last byte uses CR=8'h50 (STO|WR).

Data handshake:
- In the data-load state Wr_ready=1. The block stalls in this state while Wr_valid=0; the I2C bus is held, not released.
- A byte is taken on the cycle Wr_valid & Wr_ready.
- Exactly Req_len Wr_ready handshakes occur per write burst.

Read burst:
- SLA+W (8'h90), then raddr (8'h10).
- Repeated start SLA+R with CR=8'h90.
- Req_len bytes: CR=8'h20 (RD, ACK) for all but the last; the last uses CR=8'h68 (STO|RD|NACK).
- After TIP=0: one GET cycle with Dbus_addr=3; Rd_data <= Dbus_di and Rd_valid=1 in the following cycle.
- No back-pressure on Rd_*.

Error checks, applied after every TIP=0:
- AL (SR bit5)=1 → Err_code=2; go directly to FINISH with no STOP, since the core has already released the bus.
- Transmitted byte (address or data) with RxACK (SR bit7)=1 → Err_code=1; issue STOP (CR=8'h40), poll TIP, then FINISH.
- Timeout counter reaches TO_CYCLES → Err_code=3; issue STOP and FINISH without polling.
- Priority when both seen together: AL > NACK.
- Error detection is not applied to received bytes.

FINISH:
- Done=1 for one cycle; Err set if Err_code≠0.
- Busy=0 in the same cycle; return to IDLE.
- A new Req_start is accepted the following cycle.

Other rules:
- Req_* changes while Busy are ignored.
- Asynchronous reset mid-transaction aborts immediately and re-runs init. The core is reset by the same Rst_n.

Test Plan:
- Reset, then idle: exactly 3 writes (0←3D, 1←00, 2←80), then Dbus_wr stays 0; Busy=0.
- Write saddr=76 raddr=F4 len=2 data 27,A0 with core model ACKing: TXR sequence EC,F4,27,A0; CR sequence 90,10,10,50; two Wr_ready handshakes; Done=1, Err=0.
- Read saddr=76 raddr=FA len=3, model returns 80,00,00: TXR sequence EC,FA,ED; CR ends 20,20,68; three Rd_valid pulses with 80,00,00 in order; Done.
- Model NACKs SLA+W: Done with Err=1, Err_code=1; CR 40 issued; no Wr_ready; no raddr TXR write.
- TIP held 1 forever, TO_CYCLES=100: Err_code=3 after 100 poll cycles, CR 40 written. Separate run with AL=1 on the first byte: Err_code=2, no STOP.
- Wr_valid withheld 50 cycles mid-burst: no Dbus_wr during the stall, burst completes correctly. Rst_n pulsed mid-read: outputs go to reset values and init re-executes.
